line_buffer_pingpong: RTL and testbench

Double-buffered (ping-pong) scanline buffer for the video pipeline, generalised in data width and depth. The line fetcher writes the next line into the back bank while the pixel output stage reads the front bank. A one-cycle swap pulse at the line boundary exchanges the two banks. An optional clear engine wipes the retired bank to a fill value after each swap.

---
 rtl/video_pkg.sv | 14 +
 rtl/line_buffer_ram.sv | 42 ++++
 rtl/line_buffer_pingpong.sv | 139 +++++++++++++
 tb/tb_line_buffer_pingpong.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video-pipeline constants and the line-buffer clear FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_pkg;

  localparam int LINE_ADDR_WIDTH = 10;
  localparam int PIXEL_WIDTH     = 8;

  typedef enum logic {
    CLR_IDLE,
    CLR_SWEEP
  } line_clr_state_t;

endpackage

// File: rtl/line_buffer_ram.sv
// One scanline bank: single write port, single registered read port.
// Latency: read data valid one cycle after the address is sampled.
// Backpressure: none; both ports accept an access every cycle.
module line_buffer_ram
  import video_pkg::*;
#(
  parameter int DATA_WIDTH = PIXEL_WIDTH,
  parameter int ADDR_WIDTH = LINE_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; only the output register is cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_buffer_pingpong.sv
// Ping-pong scanline buffer: fetcher fills the back bank while output reads the front; optional
// post-swap clear sweep of the new back bank (LINE_BUFFER_AUTOCLEAR_EN). Latency: 1-cycle reads.
// Backpressure: none; writes that collide with an active clear sweep are dropped and flagged.
module line_buffer_pingpong
  import video_pkg::*;
#(
  parameter int                    DATA_WIDTH  = PIXEL_WIDTH,
  parameter int                    ADDR_WIDTH  = LINE_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  swap_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] write_addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic [ADDR_WIDTH-1:0] read_addr_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  write_bank_o,
  output logic                  clear_busy_o,
  output logic                  overrun_o
);

  logic                  bank_q, bank_d;
  logic                  rd_sel_q;
  logic                  busy;
  logic                  fetch_we;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_bank;
  logic                  ovr;

  assign bank_d = swap_i ? ~bank_q : bank_q;

  // Back-bank index, plus the front-bank select captured alongside the read address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q   <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      bank_q   <= bank_d;
      rd_sel_q <= ~bank_q;
    end
  end

`ifdef LINE_BUFFER_AUTOCLEAR_EN
  line_clr_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  clr_bank_q, clr_bank_d;
  logic                  ovr_q, ovr_d;

  // Clear engine state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CLR_IDLE;
      ptr_q      <= '0;
      clr_bank_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_bank_q <= clr_bank_d;
      ovr_q      <= ovr_d;
    end
  end

  // Clear engine next state: a swap (re)starts a sweep of the new back bank; a sweep
  // interrupted by a swap or a fetcher write raises the sticky overrun flag.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_bank_d = clr_bank_q;
    ovr_d      = ovr_q;
    clr_we     = 1'b0;
    if ((state_q == CLR_SWEEP) && (swap_i || write_i)) begin
      ovr_d = 1'b1;
    end
    if (swap_i) begin
      // The in-flight write of an aborted sweep is suppressed; that bank becomes front.
      state_d    = CLR_SWEEP;
      ptr_d      = '0;
      clr_bank_d = ~bank_q;
    end else if (state_q == CLR_SWEEP) begin
      clr_we = ~rst_i;
      ptr_d  = ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = CLR_IDLE;
      end
    end
  end

  assign busy     = (state_q == CLR_SWEEP);
  assign clr_addr = ptr_q;
  assign clr_bank = clr_bank_q;
  assign ovr      = ovr_q;
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign clr_bank = 1'b0;
  assign ovr      = 1'b0;
`endif

  // The sweep always targets the current back bank, so fetcher writes must yield to it.
  assign fetch_we = write_i & ~busy & ~rst_i;

  logic [DATA_WIDTH-1:0] bank_rdata [0:1];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic                  clr_here;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    assign clr_here = clr_we && (clr_bank == 1'(b));
    assign we       = clr_here || (fetch_we && (bank_q == 1'(b)));
    assign waddr    = clr_here ? clr_addr : write_addr_i;
    assign wdata    = clr_here ? CLEAR_VALUE : write_data_i;

    line_buffer_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (read_addr_i),
      .rdata_o (bank_rdata[b])
    );
  end

  assign read_data_o  = bank_rdata[rd_sel_q];
  assign write_bank_o = bank_q;
  assign clear_busy_o = busy;
  assign overrun_o    = ovr;

endmodule

// File: tb/tb_line_buffer_pingpong.sv
// Scoreboard bench for the ping-pong line buffer (DATA_WIDTH=8, ADDR_WIDTH=4, CLEAR_VALUE=8'hEE).
// Latency: expectations are compared shortly after the edge that consumes each stimulus cycle.
// Backpressure: n/a.
module tb_line_buffer_pingpong;

  localparam int         AW = 4;
  localparam int         DW = 8;
  localparam int         N  = 16;
  localparam logic [7:0] CV = 8'hEE;
`ifdef LINE_BUFFER_AUTOCLEAR_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          swap_i = 1'b0;
  logic          write_i = 1'b0;
  logic [AW-1:0] write_addr_i = '0;
  logic [DW-1:0] write_data_i = '0;
  logic [AW-1:0] read_addr_i = '0;
  logic [DW-1:0] read_data_o;
  logic          write_bank_o;
  logic          clear_busy_o;
  logic          overrun_o;

  line_buffer_pingpong #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .CLEAR_VALUE (CV)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .swap_i       (swap_i),
    .write_i      (write_i),
    .write_addr_i (write_addr_i),
    .write_data_i (write_data_i),
    .read_addr_i  (read_addr_i),
    .read_data_o  (read_data_o),
    .write_bank_o (write_bank_o),
    .clear_busy_o (clear_busy_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         has_data;
    logic [7:0] data;
    bit         bank;
    bit         busy;
    bit         ovr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   started = 1'b0;

  // Reference model: two line arrays, which one is back, and the pending clear work.
  logic [7:0] m_mem   [2][N];
  bit         m_known [2][N];
  int         m_bank = 0;
  bit         m_ovr = 1'b0;
  int         m_left = 0;
  int         m_cbank = 0;

  function automatic void m_write(int b, int a, logic [7:0] d);
    m_mem[b][a]   = d;
    m_known[b][a] = 1'b1;
  endfunction

  function automatic exp_t m_step(bit rst, bit sw, bit we, int wa, logic [7:0] wd, bit rd, int ra);
    exp_t e;
    bit   busy;
    e.has_data = 1'b0;
    e.data     = 8'h00;
    if (rst) begin
      m_bank     = 0;
      m_left     = 0;
      m_ovr      = 1'b0;
      e.has_data = 1'b1;
    end else begin
      e.has_data = rd && m_known[1-m_bank][ra];
      e.data     = m_mem[1-m_bank][ra];
      busy       = (m_left > 0);
      if (we) begin
        if (busy) m_ovr = 1'b1;
        else m_write(m_bank, wa, wd);
      end
      if (sw) begin
        if (busy) m_ovr = 1'b1;
        m_bank = 1 - m_bank;
        if (AC) begin
          m_cbank = m_bank;
          m_left  = N;
        end
      end else if (busy) begin
        m_write(m_cbank, N - m_left, CV);
        m_left--;
      end
    end
    e.bank = (m_bank != 0);
    e.busy = (m_left > 0);
    e.ovr  = m_ovr;
    return e;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per consumed clock edge, compared 3 time units after it.
  always @(posedge clk_i) begin
    if (started) begin
      exp_t e;
      #3;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow actual=empty required=entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (e.has_data) chk("read_data", read_data_o, e.data);
        chk("write_bank", {7'd0, write_bank_o}, {7'd0, e.bank});
        chk("clear_busy", {7'd0, clear_busy_o}, {7'd0, e.busy});
        chk("overrun", {7'd0, overrun_o}, {7'd0, e.ovr});
      end
    end
  end

  task automatic cyc(bit rst, bit sw, bit we, int wa, logic [7:0] wd, bit rd, int ra);
    rst_i        = rst;
    swap_i       = sw;
    write_i      = we;
    write_addr_i = AW'(wa);
    write_data_i = wd;
    read_addr_i  = AW'(ra);
    sb.push_back(m_step(rst, sw, we, wa, wd, rd, ra));
    started = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) cyc(0, 0, 0, 0, 8'h00, 1, a);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset, then fill bank 0 with 0x10+a and swap it to the front.
    cyc(1, 0, 0, 0, 8'h00, 1, 0);
    cyc(1, 0, 0, 0, 8'h00, 1, 0);
    for (int a = 0; a < N; a++) cyc(0, 0, 1, a, 8'(8'h10 + a), 0, 0);
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    read_all();

    // Write in the swap cycle lands in the bank that becomes front; a read in the swap
    // cycle still sees the old front bank.
    cyc(0, 1, 1, 3, 8'h55, 1, 5);
    cyc(0, 0, 0, 0, 8'h00, 1, 3);

`ifdef LINE_BUFFER_AUTOCLEAR_EN
    // Full sweep, then swap the cleared bank to the front.
    idle(16);
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    read_all();

    // Write during the sweep is dropped and flags overrun.
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 1, 7, 8'h77, 0, 0);
    idle(16);
    cyc(0, 1, 0, 0, 8'h00, 1, 7);
    cyc(0, 0, 0, 0, 8'h00, 1, 7);
    idle(15);

    // Swap at sweep cycle 5 restarts on the other bank, which ends fully cleared.
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    idle(4);
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    idle(16);
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    read_all();

    // Reset mid-sweep returns to idle and clears the sticky flag.
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0, 8'h00, 1, 0);
    idle(2);
`else
    // Twenty swaps with writes; data must survive a round trip through both roles.
    for (int s = 0; s < 20; s++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(0, 0, 1, $urandom_range(N-1), 8'($urandom), 1, $urandom_range(N-1));
      end
      cyc(0, 1, 0, 0, 8'h00, 1, $urandom_range(N-1));
      read_all();
    end
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(0, ($urandom_range(15) == 0), $urandom_range(1), $urandom_range(N-1),
          8'($urandom), 1, $urandom_range(N-1));
    end
    idle(2);

    #4;
    started = 1'b0;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
